// File: rtl/store_monitor_pkg.sv
// Shared types and constants for the store monitor: trace entry layout,
// sequence-number width and drop-counter saturation value.
package store_monitor_pkg;

  localparam int DATA_W = 16;
  localparam int SEQ_W = 8;
  localparam logic [SEQ_W-1:0] DROP_MAX = 8'd255;

  typedef struct packed {
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [SEQ_W-1:0]  seq;
  } trace_entry_t;

endpackage

// File: rtl/store_fifo.sv
// First-word-fall-through FIFO of trace entries. The head output holds the
// most recently popped entry while the FIFO is empty.
module store_fifo
  import store_monitor_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  trace_entry_t             wdata,
  output trace_entry_t             rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  trace_entry_t      mem_r [DEPTH];
  trace_entry_t      last_r;
  logic [AW-1:0]     wr_ptr_r;
  logic [AW-1:0]     rd_ptr_r;
  logic [AW:0]       count_r;
  logic              do_push_s;
  logic              do_pop_s;

  // Qualify requests: a pop needs data, a push needs room (or a same-cycle pop).
  always_comb begin
    do_pop_s  = pop && !empty;
    do_push_s = push && (!full || do_pop_s);
  end

  // Pointers and occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= (AW)'(0);
      rd_ptr_r <= (AW)'(0);
      count_r  <= (AW+1)'(0);
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + (AW)'(1);
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + (AW)'(1);
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + (AW+1)'(1);
        2'b01:   count_r <= count_r - (AW+1)'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Entry storage; slots are only read once written, so no reset is needed.
  always_ff @(posedge clk) begin
    if (do_push_s) mem_r[wr_ptr_r] <= wdata;
  end

  // Remember the last popped entry so the head holds steady when empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_r <= '0;
    end else if (do_pop_s) begin
      last_r <= mem_r[rd_ptr_r];
    end else begin
      last_r <= last_r;
    end
  end

  assign rdata = empty ? last_r : mem_r[rd_ptr_r];
  assign count = count_r;
  assign full  = (count_r == DEPTH_C);
  assign empty = (count_r == (AW+1)'(0));

endmodule

// File: rtl/store_monitor.sv
// Snoops the data-memory write port, queues each store with a sequence number
// and flags overflow and the completion store.
module store_monitor
  import store_monitor_pkg::*;
#(
  parameter int              n          = 16,
  parameter int              DEPTH      = 8,
  parameter logic [n-1:0]    MATCH_ADDR = 16'd84,
  parameter logic [n-1:0]    MATCH_DATA = 16'h0096
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    memwrite,
  input  logic [n-1:0]            dataadr,
  input  logic [n-1:0]            writedata,
  input  logic                    clear_sticky,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [n-1:0]            out_addr,
  output logic [n-1:0]            out_data,
  output logic [SEQ_W-1:0]        out_seq,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty,
  output logic                    overflow,
  output logic [SEQ_W-1:0]        drop_count,
  output logic                    pass
);

  logic [SEQ_W-1:0] seq_r;
  logic [SEQ_W-1:0] drop_count_r;
  logic             overflow_r;
  logic             pass_r;
  logic             store_s;
  logic             pop_s;
  logic             push_s;
  logic             drop_s;
  logic             match_s;
  trace_entry_t     wdata_s;
  trace_entry_t     rdata_s;

  // Store classification: pushed, dropped, and completion match.
  always_comb begin
    store_s = enable && memwrite;
    pop_s   = !empty && out_ready;
    push_s  = store_s && (!full || pop_s);
    drop_s  = store_s && full && !pop_s;
    match_s = store_s && (dataadr == MATCH_ADDR) && (writedata == MATCH_DATA);
    wdata_s = '{addr: DATA_W'(dataadr), data: DATA_W'(writedata), seq: seq_r};
  end

  store_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .wdata (wdata_s),
    .rdata (rdata_s),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Sequence numbers advance on every store, kept or dropped.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seq_r <= 8'd0;
    end else if (store_s) begin
      seq_r <= seq_r + 8'd1;
    end else begin
      seq_r <= seq_r;
    end
  end

  // Sticky flags; a same-cycle set beats clear_sticky.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_r   <= 1'b0;
      drop_count_r <= 8'd0;
      pass_r       <= 1'b0;
    end else begin
      if (drop_s) begin
        overflow_r   <= 1'b1;
        drop_count_r <= (drop_count_r == DROP_MAX) ? DROP_MAX : drop_count_r + 8'd1;
      end else if (clear_sticky) begin
        overflow_r   <= 1'b0;
        drop_count_r <= 8'd0;
      end else begin
        overflow_r   <= overflow_r;
        drop_count_r <= drop_count_r;
      end
      if (match_s) begin
        pass_r <= 1'b1;
      end else if (clear_sticky) begin
        pass_r <= 1'b0;
      end else begin
        pass_r <= pass_r;
      end
    end
  end

  assign out_valid  = !empty;
  assign out_addr   = n'(rdata_s.addr);
  assign out_data   = n'(rdata_s.data);
  assign out_seq    = rdata_s.seq;
  assign overflow   = overflow_r;
  assign drop_count = drop_count_r;
  assign pass       = pass_r;

endmodule
